// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: shared FSM state encoding and word-size helper for the spill/fill controller
package rf_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, SPILL_XFER, FILL_REQ, FILL_WAIT, ERR} state_t;
  function automatic int unsigned word_bytes(input int unsigned dwidth);
    return dwidth / 8;
  endfunction
endpackage

// File: rtl/rf_stack_ptr.sv
// rf_stack_ptr: spill stack pointer with push/pop by one word and whole-window overflow/underflow checks
// Ports: clk, rst (sync active-high), inc/dec (move by one word), sp (next free byte),
//        ovf_chk (a full window would exceed the limit), unf_chk (fewer than one window stacked)
module rf_stack_ptr import rf_ctrl_pkg::*; #(
  parameter int unsigned DWIDTH = 64,
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned NWORDS = 16,
  parameter int unsigned STACK_BASE = 'h1000,
  parameter int unsigned STACK_LIMIT = 'h2000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [AWIDTH-1:0] sp,
  output logic              ovf_chk,
  output logic              unf_chk
);
  localparam int unsigned WB = word_bytes(DWIDTH);
  localparam logic [AWIDTH:0] SPAN = (AWIDTH+1)'(NWORDS * WB);
  localparam logic [AWIDTH:0] LIM = (AWIDTH+1)'(STACK_LIMIT);
  localparam logic [AWIDTH:0] FLOOR = (AWIDTH+1)'(STACK_BASE) + SPAN;
  // one extra bit so a pointer near the top of the address space cannot wrap past the limit
  assign ovf_chk = {1'b0, sp} + SPAN > LIM;
  assign unf_chk = {1'b0, sp} < FLOOR;
  always_ff @(posedge clk)
    sp <= rst ? AWIDTH'(STACK_BASE) : inc ? sp + AWIDTH'(WB) : dec ? sp - AWIDTH'(WB) : sp;
endmodule

// File: rtl/rf_spill_fill_ctrl.sv
// rf_spill_fill_ctrl: moves one register window between the register file and a memory stack (spill/fill)
// Ports: CLK, RESET (sync active-high); SPILL/FILL requests, MEM_BUS spill word in, MEM_BUSread fill word out,
//        RF_ADV word-pointer pulse, RF_ENABLE pipeline enable; MEM_REQ/WE/ADDR/WDATA/GNT/RVALID/RDATA memory port;
//        DONE completion pulse, OVF/UNF sticky error flags, SP stack pointer
module rf_spill_fill_ctrl import rf_ctrl_pkg::*; #(
  parameter int unsigned DWIDTH = 64,
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned NWORDS = 16,
  parameter int unsigned STACK_BASE = 'h1000,
  parameter int unsigned STACK_LIMIT = 'h2000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SPILL,
  input  logic              FILL,
  input  logic [DWIDTH-1:0] MEM_BUS,
  output logic [DWIDTH-1:0] MEM_BUSread,
  output logic              RF_ADV,
  output logic              RF_ENABLE,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [AWIDTH-1:0] MEM_ADDR,
  output logic [DWIDTH-1:0] MEM_WDATA,
  input  logic              MEM_GNT,
  input  logic              MEM_RVALID,
  input  logic [DWIDTH-1:0] MEM_RDATA,
  output logic              DONE,
  output logic              OVF,
  output logic              UNF,
  output logic [AWIDTH-1:0] SP
);
  localparam int unsigned WB = word_bytes(DWIDTH);
  localparam int CW = $clog2(NWORDS) + 1;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic inc, dec, rd_ret, last, adv_q, ovf_chk, unf_chk;
  assign inc = state == SPILL_XFER && MEM_GNT;
  assign dec = state == FILL_REQ && MEM_GNT;
  assign rd_ret = state == FILL_WAIT && MEM_RVALID;
  assign last = cnt == CW'(NWORDS - 1);
  rf_stack_ptr #(
    .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .NWORDS(NWORDS),
    .STACK_BASE(STACK_BASE), .STACK_LIMIT(STACK_LIMIT)
  ) u_sp (
    .clk(CLK), .rst(RESET), .inc(inc), .dec(dec), .sp(SP), .ovf_chk(ovf_chk), .unf_chk(unf_chk)
  );
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      cnt <= '0;
      adv_q <= 1'b0;
      DONE <= 1'b0;
      OVF <= 1'b0;
      UNF <= 1'b0;
      MEM_BUSread <= '0;
    end else begin
      state <= nxt;
      cnt <= state == IDLE ? '0 : (inc || rd_ret) ? cnt + CW'(1) : cnt;
      // fill word is registered, so the register file's advance pulse follows it by a cycle
      adv_q <= rd_ret;
      DONE <= (inc || rd_ret) && last;
      OVF <= OVF | (state == IDLE && SPILL && ovf_chk);
      UNF <= UNF | (state == IDLE && !SPILL && FILL && unf_chk);
      MEM_BUSread <= rd_ret ? MEM_RDATA : MEM_BUSread;
    end
  end
  always_comb begin
    nxt = state;
    RF_ENABLE = state == IDLE;
    MEM_REQ = state == SPILL_XFER || state == FILL_REQ;
    MEM_WE = state == SPILL_XFER;
    MEM_ADDR = state == SPILL_XFER ? SP : state == FILL_REQ ? SP - AWIDTH'(WB) : '0;
    MEM_WDATA = state == SPILL_XFER ? MEM_BUS : '0;
    RF_ADV = inc | adv_q;
    case (state)
      IDLE:       nxt = SPILL ? (ovf_chk ? ERR : SPILL_XFER) : FILL ? (unf_chk ? ERR : FILL_REQ) : IDLE;
      SPILL_XFER: nxt = inc && last ? IDLE : SPILL_XFER;
      FILL_REQ:   nxt = MEM_GNT ? FILL_WAIT : FILL_REQ;
      FILL_WAIT:  nxt = MEM_RVALID ? (last ? IDLE : FILL_REQ) : FILL_WAIT;
      default:    nxt = ERR;
    endcase
  end
endmodule

// File: tb/tb_rf_spill_fill_ctrl.sv
// tb_rf_spill_fill_ctrl: directed self-checking bench for rf_spill_fill_ctrl with a 4-word window
module tb_rf_spill_fill_ctrl;
  logic CLK = 1'b0, RESET = 1'b1, SPILL = 1'b0, FILL = 1'b0;
  logic MEM_GNT = 1'b1, MEM_RVALID = 1'b0;
  logic [63:0] MEM_BUS = '0, MEM_RDATA = '0, MEM_BUSread, MEM_WDATA;
  logic [31:0] MEM_ADDR, SP;
  logic RF_ADV, RF_ENABLE, MEM_REQ, MEM_WE, DONE, OVF, UNF;
  logic [63:0] mem [0:7];
  int n_chk = 0, n_fail = 0;

  rf_spill_fill_ctrl #(
    .DWIDTH(64), .AWIDTH(32), .NWORDS(4), .STACK_BASE('h1000), .STACK_LIMIT('h1040)
  ) dut (
    .CLK(CLK), .RESET(RESET), .SPILL(SPILL), .FILL(FILL), .MEM_BUS(MEM_BUS), .MEM_BUSread(MEM_BUSread),
    .RF_ADV(RF_ADV), .RF_ENABLE(RF_ENABLE), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_GNT(MEM_GNT), .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA),
    .DONE(DONE), .OVF(OVF), .UNF(UNF), .SP(SP)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    #1;
    chk("rst_en", RF_ENABLE, 1);
    chk("rst_req", MEM_REQ, 0);
    chk("rst_sp", SP, 'h1000);
    chk("rst_flags", {OVF, UNF, DONE, RF_ADV, MEM_WE}, 0);
    chk("rst_addr", MEM_ADDR, 0);
    chk("rst_wdata", MEM_WDATA, 0);
    chk("rst_busread", MEM_BUSread, 0);
  endtask

  task automatic do_spill(input logic [31:0] sp0, input logic [63:0] seed, input logic both);
    SPILL = 1'b1;
    FILL = both;
    tick();
    SPILL = 1'b0;
    FILL = 1'b0;
    for (int i = 0; i < 4; i++) begin
      MEM_BUS = seed + 64'(i);
      #1;
      chk("sp_req", {MEM_REQ, MEM_WE, RF_ENABLE}, 3'b110);
      chk("sp_addr", MEM_ADDR, sp0 + 32'(8 * i));
      chk("sp_wdata", MEM_WDATA, seed + 64'(i));
      chk("sp_adv", RF_ADV, 1);
      chk("sp_done", DONE, 0);
      mem[(sp0 - 'h1000) / 8 + 32'(i)] = seed + 64'(i);
      tick();
    end
    #1;
    chk("sp_end_done", DONE, 1);
    chk("sp_end_en", RF_ENABLE, 1);
    chk("sp_end_req", MEM_REQ, 0);
    chk("sp_end_sp", SP, sp0 + 'h20);
    tick();
    chk("sp_done_pulse", DONE, 0);
  endtask

  task automatic do_fill(input logic [31:0] sp0);
    logic [31:0] a;
    FILL = 1'b1;
    tick();
    FILL = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = sp0 - 32'(8 * (i + 1));
      #1;
      chk("fl_req", {MEM_REQ, MEM_WE, RF_ENABLE}, 3'b100);
      chk("fl_addr", MEM_ADDR, a);
      tick();
      chk("fl_wait_req", MEM_REQ, 0);
      chk("fl_wait_adv", RF_ADV, 0);
      MEM_RVALID = 1'b1;
      MEM_RDATA = mem[(a - 'h1000) / 8];
      tick();
      MEM_RVALID = 1'b0;
      MEM_RDATA = '0;
      chk("fl_adv", RF_ADV, 1);
      chk("fl_data", MEM_BUSread, mem[(a - 'h1000) / 8]);
      chk("fl_done", DONE, i == 3);
    end
    chk("fl_end_sp", SP, sp0 - 'h20);
    chk("fl_end_en", RF_ENABLE, 1);
    tick();
    chk("fl_done_pulse", DONE, 0);
    chk("fl_hold", MEM_BUSread, mem[(sp0 - 'h20 - 'h1000) / 8]);
  endtask

  initial begin
    do_reset();
    // plain spill, then LIFO fill back
    do_spill('h1000, 64'hA000_0000_0000_0010, 1'b0);
    do_fill('h1020);
    chk("fill_rev_first", mem[3], 64'hA000_0000_0000_0013);
    // SPILL and FILL together: spill wins
    do_spill('h1000, 64'hB000_0000_0000_0020, 1'b1);
    do_spill('h1020, 64'hC000_0000_0000_0030, 1'b0);
    chk("full_sp", SP, 'h1040);
    // overflow
    SPILL = 1'b1;
    #1;
    chk("ovf_noreq", MEM_REQ, 0);
    tick();
    SPILL = 1'b0;
    chk("ovf_flag", {OVF, UNF}, 2'b10);
    chk("ovf_en", RF_ENABLE, 0);
    chk("ovf_req", MEM_REQ, 0);
    FILL = 1'b1;
    tick();
    FILL = 1'b0;
    tick();
    chk("err_stuck", {RF_ENABLE, MEM_REQ, OVF, UNF}, 4'b0010);
    chk("err_sp", SP, 'h1040);
    // underflow
    do_reset();
    FILL = 1'b1;
    tick();
    FILL = 1'b0;
    chk("unf_flag", {OVF, UNF}, 2'b01);
    for (int i = 0; i < 3; i++) begin
      chk("unf_en", {RF_ENABLE, MEM_REQ}, 0);
      tick();
    end
    chk("unf_sp", SP, 'h1000);
    // grant stall, then reset mid-spill
    do_reset();
    SPILL = 1'b1;
    tick();
    SPILL = 1'b0;
    MEM_BUS = 64'h1111;
    tick();
    MEM_BUS = 64'h2222;
    MEM_GNT = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_addr", MEM_ADDR, 'h1008);
      chk("stall_wdata", MEM_WDATA, 64'h2222);
      chk("stall_adv", {RF_ADV, MEM_REQ}, 2'b01);
      tick();
    end
    MEM_GNT = 1'b1;
    tick();
    MEM_GNT = 1'b0;
    MEM_BUS = 64'h3333;
    #1;
    chk("w2_addr", MEM_ADDR, 'h1010);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    MEM_GNT = 1'b1;
    #1;
    chk("mid_rst_en", RF_ENABLE, 1);
    chk("mid_rst_sp", SP, 'h1000);
    chk("mid_rst_req", {MEM_REQ, DONE, RF_ADV}, 0);
    chk("mid_rst_addr", MEM_ADDR, 0);
    // read return arriving after reset is dropped
    do_spill('h1000, 64'hD000_0000_0000_0040, 1'b0);
    FILL = 1'b1;
    tick();
    FILL = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    MEM_RVALID = 1'b1;
    MEM_RDATA = 64'hDEAD;
    tick();
    MEM_RVALID = 1'b0;
    chk("late_rd_data", MEM_BUSread, 0);
    chk("late_rd_adv", {RF_ADV, DONE, MEM_REQ}, 0);
    chk("late_rd_sp", SP, 'h1000);
    chk("late_rd_en", RF_ENABLE, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
